tc2sm_24bit: RTL

TC2SM_24BIT -- requirements
Module: tc2sm_24bit

---
 rtl/tc2sm_24bit_if.sv | 33 +++
 rtl/tc2sm_24bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tc2sm_24bit_if.sv
// tc2sm_24bit_if -- handshake and data bundle for the two's-complement to
// sign/magnitude converter.
//
//   in_valid   producer -> converter   X is valid
//   in_ready   converter -> producer   converter can accept X
//   X          producer -> converter   25-bit two's-complement operand
//   out_valid  converter -> consumer   Sign/Mag/Ovf are valid
//   out_ready  consumer -> converter   consumer takes the result
//   Sign       converter -> consumer   sign of X
//   Mag        converter -> consumer   |X|, unsigned 24 bits
//   Ovf        converter -> consumer   |X| needs 25 bits (X = -2^24)
//
// slave modport is the converter side, master modport the producer/consumer.
interface tc2sm_24bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] X;
    logic        out_valid;
    logic        out_ready;
    logic        Sign;
    logic [23:0] Mag;
    logic        Ovf;

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, Sign, Mag, Ovf
    );

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, Sign, Mag, Ovf
    );
endinterface

// File: rtl/tc2sm_24bit.sv
// tc2sm_24bit -- nibble-serial two's-complement to sign/magnitude converter.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    tc2sm_24bit_if.slave (in_valid/in_ready/X in, out_valid/out_ready/
//          Sign/Mag/Ovf out)
//
// A negative operand is negated as ~X + 1, one nibble per cycle, LSB first,
// with the +1 entering as the initial carry. Six CONV cycles cover 24 bits.
//
// Optional macro TC2SM_FAST_POS_EN: non-negative operands skip CONV and load
// Mag = X[23:0] directly, reaching DONE on the accepting edge.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid
// CONV  | converting nibble nib_idx (0..5) of the captured operand
// DONE  | out_valid high, result held until out_ready
module tc2sm_24bit (
    input  logic           clk,
    input  logic           rst_n,
    tc2sm_24bit_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state;
    logic [23:0] x_reg;
    logic [23:0] mag_r;
    logic [23:0] mag_next;
    logic        sign_r;
    logic        ovf_r;
    logic        carry_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [2:0]  nib_idx;
    logic [3:0]  x_nib;
    logic [4:0]  nib_sum;

    always_comb begin
        case (nib_idx)
            3'd0:    x_nib = x_reg[3:0];
            3'd1:    x_nib = x_reg[7:4];
            3'd2:    x_nib = x_reg[11:8];
            3'd3:    x_nib = x_reg[15:12];
            3'd4:    x_nib = x_reg[19:16];
            default: x_nib = x_reg[23:20];
        endcase
        nib_sum  = {1'b0, (sign_r ? ~x_nib : x_nib)} + {4'b0000, carry_r};
        mag_next = mag_r;
        for (int k = 0; k < 6; k++) begin
            if (nib_idx == 3'(k)) begin
                mag_next[4*k +: 4] = nib_sum[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_reg       <= '0;
            mag_r       <= '0;
            sign_r      <= 1'b0;
            ovf_r       <= 1'b0;
            carry_r     <= 1'b0;
            nib_idx     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef TC2SM_FAST_POS_EN
                        if (!bus.X[24]) begin
                            mag_r       <= bus.X[23:0];
                            sign_r      <= 1'b0;
                            ovf_r       <= 1'b0;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            x_reg      <= bus.X[23:0];
                            sign_r     <= bus.X[24];
                            carry_r    <= bus.X[24];
                            nib_idx    <= '0;
                            in_ready_r <= 1'b0;
                            state      <= CONV;
                        end
`else
                        x_reg      <= bus.X[23:0];
                        sign_r     <= bus.X[24];
                        carry_r    <= bus.X[24];
                        nib_idx    <= '0;
                        in_ready_r <= 1'b0;
                        state      <= CONV;
`endif
                    end
                end
                CONV: begin
                    mag_r   <= mag_next;
                    carry_r <= nib_sum[4];
                    nib_idx <= nib_idx + 3'd1;
                    if (nib_idx == 3'd5) begin
                        // Carry out of the top nibble survives only for -2^24.
                        ovf_r       <= sign_r & nib_sum[4];
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.Sign      = sign_r;
    assign bus.Mag       = mag_r;
    assign bus.Ovf       = ovf_r;

endmodule
